// File: rtl/alu_nbit_seg_scan.sv
// Registered N-bit ALU with carry/zero/overflow flags, driving a multiplexed
// hex 7-segment display with leading-zero blanking and the carry on digit 0's dp.
`timescale 1ns/1ps
module alu_nbit_seg_scan #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [2:0]        ALU_Sel,
  input  logic              load,
  output logic [WIDTH-1:0]  result,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_v,
  output logic              result_valid,
  output logic [DIGITS-1:0] Segment_Sel,
  output logic [7:0]        Segment_Out
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PreW = $clog2(SCAN_DIV);
  localparam logic [7:0]        SegOff = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [PreW-1:0]   PreMax = PreW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]   IdxMax = IdxW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SelOne = DIGITS'(1);

  // Active-high gfedcba hex font.
  function automatic logic [6:0] seg_font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  logic [WIDTH:0]     sum_ext, diff_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;

  logic [WIDTH-1:0]   result_q;
  logic               flag_c_q, flag_z_q, flag_v_q, valid_q;

  logic [PreW-1:0]    presc_q;
  logic [IdxW-1:0]    digit_idx_q;

  logic [WIDTH-1:0]   shifted;
  logic               blank;
  logic [7:0]         seg_raw, seg_out_d;
  logic [DIGITS-1:0]  seg_sel_d;
  logic [7:0]         seg_out_q;
  logic [DIGITS-1:0]  seg_sel_q;

  // Combinational ALU: result and flags for the current operands/select.
  always_comb begin
    sum_ext  = {1'b0, A} + {1'b0, B};
    diff_ext = {1'b0, A} - {1'b0, B};
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (ALU_Sel)
      3'b000: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      3'b001: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];  // borrow: A < B unsigned
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff_ext[WIDTH-1] != A[WIDTH-1]);
      end
      3'b010: alu_res = A & B;
      3'b011: alu_res = A | B;
      3'b100: alu_res = A ^ B;
      3'b101: alu_res = ~A;
      3'b110: begin
        alu_res = {A[WIDTH-2:0], 1'b0};
        alu_c   = A[WIDTH-1];
      end
      3'b111: begin
        alu_res = {1'b0, A[WIDTH-1:1]};
        alu_c   = A[0];
      end
      default: ;
    endcase
  end

  // Result and flag registers, captured on every cycle load is high.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
      valid_q  <= 1'b0;
    end else if (load) begin
      result_q <= alu_res;
      flag_c_q <= alu_c;
      flag_z_q <= (alu_res == '0);
      flag_v_q <= alu_v;
      valid_q  <= 1'b1;
    end
  end

  // Scan prescaler and digit index; the index advances on the prescaler wrap.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      digit_idx_q <= '0;
    end else if (presc_q == PreMax) begin
      presc_q     <= '0;
      digit_idx_q <= (digit_idx_q == IdxMax) ? '0 : digit_idx_q + 1'b1;
    end else begin
      presc_q     <= presc_q + 1'b1;
    end
  end

  // Decode the selected digit: nibble, leading-zero blanking and carry on dp.
  always_comb begin
    shifted   = result_q >> {digit_idx_q, 2'b00};
    // Everything from this nibble upward is zero -> leading zero (digit 0 excepted).
    blank     = (digit_idx_q != '0) && (shifted == '0);
    seg_raw   = {(digit_idx_q == '0) && flag_c_q, blank ? 7'h00 : seg_font(shifted[3:0])};
    seg_out_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    seg_sel_d = SelOne << digit_idx_q;
  end

  // Select and segments registered together so they always refer to the same digit.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      seg_sel_q <= '0;
      seg_out_q <= SegOff;
    end else begin
      seg_sel_q <= seg_sel_d;
      seg_out_q <= seg_out_d;
    end
  end

  assign result       = result_q;
  assign flag_c       = flag_c_q;
  assign flag_z       = flag_z_q;
  assign flag_v       = flag_v_q;
  assign result_valid = valid_q;
  assign Segment_Sel  = seg_sel_q;
  assign Segment_Out  = seg_out_q;

endmodule

// File: tb/tb_alu_nbit_seg_scan.sv
// Self-checking bench for alu_nbit_seg_scan: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_alu_nbit_seg_scan;

  localparam int WIDTH    = 8;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam bit SEG_ACTIVE_LOW = 1'b0;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic [2:0]        alu_sel = '0;
  logic              load = 1'b0;
  logic [WIDTH-1:0]  result;
  logic              flag_c, flag_z, flag_v, result_valid;
  logic [DIGITS-1:0] Segment_Sel;
  logic [7:0]        Segment_Out;

  int n_pass  = 0;
  int n_total = 0;

  alu_nbit_seg_scan #(
    .WIDTH(WIDTH),
    .DIGITS(DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) dut (
    .sys_clk(clk),
    .reset(reset),
    .A(a),
    .B(b),
    .ALU_Sel(alu_sel),
    .load(load),
    .result(result),
    .flag_c(flag_c),
    .flag_z(flag_z),
    .flag_v(flag_v),
    .result_valid(result_valid),
    .Segment_Sel(Segment_Sel),
    .Segment_Out(Segment_Out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] font(input int n);
    logic [6:0] f;
    case (n)
      0: f = 7'h3F;  1: f = 7'h06;  2: f = 7'h5B;  3: f = 7'h4F;
      4: f = 7'h66;  5: f = 7'h6D;  6: f = 7'h7D;  7: f = 7'h07;
      8: f = 7'h7F;  9: f = 7'h6F; 10: f = 7'h77; 11: f = 7'h7C;
      12: f = 7'h39; 13: f = 7'h5E; 14: f = 7'h79; default: f = 7'h71;
    endcase
    return f;
  endfunction

  // What digit idx must show for a given result and carry.
  function automatic logic [7:0] expect_seg(input int r, input bit c, input int idx);
    logic [7:0] s;
    int rest;
    rest = r >> (4 * idx);
    s = 8'h00;
    if (idx == 0 || rest != 0) s[6:0] = font(rest % 16);
    if (idx == 0 && c) s[7] = 1'b1;
    if (SEG_ACTIVE_LOW) s = ~s;
    return s;
  endfunction

  // ALU reference using plain integer arithmetic.
  task automatic alu_ref(input int x, input int y, input int s,
                         output int r, output bit c, output bit v);
    int modv, half, sx, sy, t;
    modv = 1 << WIDTH;
    half = 1 << (WIDTH - 1);
    sx = (x >= half) ? x - modv : x;
    sy = (y >= half) ? y - modv : y;
    c = 1'b0;
    v = 1'b0;
    case (s)
      0: begin
        t = x + y;
        r = t % modv;
        c = (t >= modv);
        v = ((sx + sy) >= half) || ((sx + sy) < -half);
      end
      1: begin
        r = (x - y + modv) % modv;
        c = (x < y);
        v = ((sx - sy) >= half) || ((sx - sy) < -half);
      end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = (modv - 1) - x;
      6: begin
        r = (x * 2) % modv;
        c = (x >= half);
      end
      default: begin
        r = x / 2;
        c = (x % 2) != 0;
      end
    endcase
  endtask

  // Model state.
  int                m_result;
  bit                m_c, m_z, m_v, m_valid;
  int                m_edges;
  logic [DIGITS-1:0] m_sel;
  logic [7:0]        m_out;

  // Step the model on every clock edge and compare all outputs just after it.
  always @(posedge clk) begin : model_step
    int idx;
    int r;
    bit c, v;
    if (reset) begin
      m_result = 0; m_c = 0; m_z = 0; m_v = 0; m_valid = 0;
      m_edges  = 0;
      m_sel    = '0;
      m_out    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    end else begin
      // Display shows the digit selected by elapsed scan time, from the pre-edge result.
      idx   = (m_edges / SCAN_DIV) % DIGITS;
      m_sel = DIGITS'(1 << idx);
      m_out = expect_seg(m_result, m_c, idx);
      if (load) begin
        alu_ref(int'(a), int'(b), int'(alu_sel), r, c, v);
        m_result = r; m_c = c; m_v = v; m_z = (r == 0); m_valid = 1'b1;
      end
      m_edges++;
    end
    #1;
    check("cyc_result", result, m_result);
    check("cyc_flag_c", flag_c, m_c);
    check("cyc_flag_z", flag_z, m_z);
    check("cyc_flag_v", flag_v, m_v);
    check("cyc_valid", result_valid, m_valid);
    check("cyc_sel", Segment_Sel, m_sel);
    check("cyc_seg", Segment_Out, m_out);
  end

  task automatic load_op(input int av, input int bv, input int sv);
    a = WIDTH'(av);
    b = WIDTH'(bv);
    alu_sel = 3'(sv);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Wait (bounded) until the given digit is driven, then check its segments.
  task automatic show_digit(input logic [DIGITS-1:0] target, input logic [7:0] exp,
                            input string name);
    bit found;
    found = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (Segment_Sel == target) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (found) check(name, Segment_Out, exp);
    else begin
      n_total++;
      $display("FAIL %s: select 0x%0h never seen, got 0x%0h", name, target, Segment_Sel);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [DIGITS-1:0] t1_sel [5];
    logic [7:0]        t1_out [5];
    t1_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    t1_out = '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h3F};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_sel", Segment_Sel, 0);
    check("rst_seg", Segment_Out, 8'h00);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    reset = 1'b0;

    // 1: free-running scan, no load.
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k % 4 == 1) begin
        check("t1_sel", Segment_Sel, t1_sel[(k - 1) / 4]);
        check("t1_seg", Segment_Out, t1_out[(k - 1) / 4]);
        check("t1_valid", result_valid, 0);
      end
    end

    // 2: F0 + 20 -> 10 with carry.
    load_op('hF0, 'h20, 0);
    check("t2_result", result, 8'h10);
    check("t2_c", flag_c, 1);
    check("t2_z", flag_z, 0);
    check("t2_v", flag_v, 0);
    check("t2_valid", result_valid, 1);
    show_digit(4'b0001, 8'hBF, "t2_d0");
    show_digit(4'b0010, 8'h06, "t2_d1");
    show_digit(4'b0100, 8'h00, "t2_d2");
    show_digit(4'b1000, 8'h00, "t2_d3");

    // 3: subtract to zero, then borrow.
    load_op('h05, 'h05, 1);
    check("t3_result0", result, 8'h00);
    check("t3_z", flag_z, 1);
    check("t3_c0", flag_c, 0);
    show_digit(4'b0001, 8'h3F, "t3_d0_zero");
    show_digit(4'b0010, 8'h00, "t3_d1_blank");
    load_op('h05, 'h06, 1);
    check("t3_resultff", result, 8'hFF);
    check("t3_c1", flag_c, 1);
    check("t3_v", flag_v, 0);
    show_digit(4'b0001, 8'hF1, "t3_d0_f");
    show_digit(4'b0010, 8'h71, "t3_d1_f");

    // 4: signed overflow, shift-left carry out.
    load_op('h7F, 'h01, 0);
    check("t4_result80", result, 8'h80);
    check("t4_v1", flag_v, 1);
    check("t4_c0", flag_c, 0);
    load_op('h81, 'h00, 6);
    check("t4_result02", result, 8'h02);
    check("t4_c1", flag_c, 1);
    check("t4_v0", flag_v, 0);

    // 5: reset in the middle of digit 2.
    show_digit(4'b0100, 8'h00, "t5_d2");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_sel", Segment_Sel, 0);
    check("t5_seg", Segment_Out, 8'h00);
    check("t5_result", result, 0);
    check("t5_valid", result_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t5_restart_sel", Segment_Sel, 4'b0001);
    check("t5_restart_seg", Segment_Out, 8'h3F);

    // 6: load held high with A incrementing.
    b = 8'h10;
    alu_sel = 3'b000;
    for (int i = 0; i < 6; i++) begin
      a = WIDTH'(8'h20 + i);
      load = 1'b1;
      @(negedge clk);
      check("t6_result", result, 32'h30 + i);
    end
    load = 1'b0;
    show_digit(4'b0010, 8'h4F, "t6_d1");

    // 7: randomized traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 300; i++) begin
      a = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      b = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      alu_sel = 3'($urandom_range(0, 7));
      load = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    load = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
